// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/8-data/stop-bit serialiser.
// Back-to-back frames chain straight from the last stop cycle into the next start bit.
module uart_tx_fifo #(
    parameter int BIT_WIDTH     = 11,
    parameter int BAUD_RATE     = 230400,
    parameter int CLOCK_FREQ_HZ = 100000000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          send,
    input  logic [7:0]                    tx_data,
    output logic                          ready,
    output logic                          overflow,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int STOP_BITS    = BIT_WIDTH - 9;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];

    logic wr, pop, baud_done, frame_end;

    assign ready      = count_q < CNT_W'(FIFO_DEPTH);
    assign overflow   = ovf_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign tx         = tx_q;

    always_comb begin
        // Room is judged on the registered count only, so a same-cycle pop never admits a write.
        wr        = send && ready;
        baud_done = (baud_q == BAUD_LAST);
        frame_end = (state_q == STOP) && baud_done && (bit_q == STOP_LAST);
        pop       = (count_q != '0) && ((state_q == IDLE) || frame_end);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = send && !ready;
        count_d  = count_q + CNT_W'(wr) - CNT_W'(pop);
        if (wr) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        baud_d  = (state_q == IDLE || baud_done) ? '0 : baud_q + BAUD_W'(1);
        case (state_q)
            IDLE: tx_d = 1'b1;
            START: if (baud_done) begin
                state_d = DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
            end
            DATA: if (baud_done) begin
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            STOP: if (baud_done) begin
                if (bit_q == STOP_LAST) state_d = IDLE;
                else                    bit_d   = bit_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            baud_d  = '0;
            bit_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter. It is the send-side counterpart of the receive path that decodes incoming command bytes.
- Accepts bytes on a send/tx_data strobe interface into a small FIFO.
- Serialises each byte onto tx as start bit, 8 data bits LSB first, then stop bits.
- Sits between command/status logic in top and the board's tx pin, so bursts such as replies or status strings can be queued without waiting on each frame.

Parameters:
- BIT_WIDTH, 11, total frame bits including start and stop bits. Stop bits = BIT_WIDTH-9. Legal range 10..12.
- BAUD_RATE, 230400, line bit rate in bit/s.
- CLOCK_FREQ_HZ, 100000000, clk frequency. CLKS_PER_BIT = CLOCK_FREQ_HZ/BAUD_RATE, truncated; must be >= 2.
- FIFO_DEPTH, 4, byte buffer entries. Power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- send  in  1  write strobe; one byte enqueued per cycle high while ready=1.
- tx_data  in  8  byte sampled on the edge where send=1.
- ready  out  1  high when FIFO is not full (count < FIFO_DEPTH).
- overflow  out  1  one-cycle pulse on the edge after send=1 while ready=0.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.
- tx  out  1  serial line, registered, idle high.

Behaviour:
- Reset (async, active-high):
  - tx=1, ready=1, overflow=0, busy=0, fifo_count=0.
  - FIFO pointers cleared; FSM to IDLE; baud counter and bit index cleared.
  - Reset asserted mid-frame aborts the frame: tx returns high immediately, queued bytes are discarded.
- FIFO:
  - Write when send=1 and ready=1 at the edge.
  - A write while full is dropped; FIFO contents unchanged; overflow pulses.
  - ready reflects registered count. A pop in the same cycle does not make room for a write in that cycle; the write is still dropped.
  - Simultaneous write and pop with 0 < count < FIFO_DEPTH: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty at an edge, pop the head into the shift register, go to START, drive tx=0.
  - Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1; tx falls at edge N+1.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA with bit index 0, tx=data[0].
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. After bit 7, go to STOP, tx=1.
  - STOP: hold for (BIT_WIDTH-9)*CLKS_PER_BIT cycles.
    - At the final cycle, if the FIFO is non-empty: pop and go straight to START. No idle gap; back-to-back frames are exactly BIT_WIDTH*CLKS_PER_BIT cycles apart.
    - Otherwise go to IDLE.
- Baud counter: 0..CLKS_PER_BIT-1; advance bit on terminal count; reset to 0 on every state entry.
- busy = (state != IDLE) or (fifo_count != 0).
- The byte being shifted is held in the shift register; its FIFO slot is freed at pop. A full FIFO plus one in-flight byte gives FIFO_DEPTH+1 bytes outstanding.
- tx_data changes while a frame is in flight do not affect the frame.

Test Plan:
Bench uses CLOCK_FREQ_HZ=1000, BAUD_RATE=100 (CLKS_PER_BIT=10), BIT_WIDTH=11, FIFO_DEPTH=4.

1. Single byte: after reset, send=1 with tx_data=8'h31 for one cycle.
   - tx falls 1 cycle later; low for 10 cycles.
   - Then bits 1,0,0,0,1,1,0,0 at 10 cycles each, then high for 20 cycles.
   - busy high from the edge after send until stop completes; fifo_count back to 0 on the pop edge.
2. Back-to-back: send 8'h31, 8'h32, 8'h33 on three consecutive cycles.
   - Three frames, start bits exactly 110 cycles apart.
   - fifo_count peaks at 2; busy drops 330 cycles after the first start bit.
3. Overflow: send 6 bytes 8'hA0..8'hA5 on consecutive cycles from idle.
   - 8'hA0 pops; 8'hA1..8'hA4 fill the FIFO (ready=0 after 8'hA4).
   - 8'hA5 dropped; overflow pulses exactly once.
   - Line carries A0..A4 in order.
4. Full with simultaneous pop: fill the FIFO, then assert send with 8'h55 on the exact edge a pop occurs.
   - Byte dropped, overflow pulses, fifo_count stays at 3 after the pop.
   - On the next cycle, send 8'h55 is accepted.
5. Reset mid-frame: send 8'h00, assert rst during DATA bit 3.
   - tx=1 within the same cycle (async); fifo_count=0; busy=0.
   - A later send of 8'hFF produces a clean, complete frame.
6. Wrap-around: push and drain 10 sequential bytes 8'h01..8'h0A in bursts of 3.
   - Pointers wrap; line order is exactly 01..0A.
   - No overflow pulse.
